// File: rtl/dmem_ctrl_if.sv
// CPU-side request/response and RAM-side port bundle for the data-memory controller.
interface dmem_ctrl_if #(
    parameter int unsigned ADDR_W = 14
);
    logic              req;
    logic [31:0]       ir;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic              busy;
    logic              done;
    logic [31:0]       rdata;
    logic              misalign;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;
    logic              mem_we;
    logic              mem_re;
    logic [31:0]       mem_rdata;

    // Requester plus RAM side: drives requests and read data, observes the controller.
    modport master (
        output req, ir, addr, wdata, mem_rdata,
        input  busy, done, rdata, misalign, mem_addr, mem_wdata, mem_be, mem_we, mem_re
    );

    // Controller side.
    modport slave (
        input  req, ir, addr, wdata, mem_rdata,
        output busy, done, rdata, misalign, mem_addr, mem_wdata, mem_be, mem_we, mem_re
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory access controller: one load/store at a time against a fixed-latency word RAM.
module dmem_ctrl #(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned WR_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    dmem_ctrl_if.slave bus
);
    localparam int unsigned CNT_W = 3;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DONE} state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              accept, capture;
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic              is_st, is_ld, mis_c;
    logic [3:0]        be_c;
    logic              unused_bits;

    assign opcode = bus.ir[6:0];
    assign funct3 = bus.ir[14:12];
    assign unused_bits = ^{bus.ir[31:15], bus.ir[11:7], bus.addr[31:ADDR_W+2]};

    // Width/alignment decode of the presented request.
    always_comb begin
        is_st = (opcode == OP_STORE) && (funct3 inside {3'b000, 3'b001, 3'b010});
        is_ld = (opcode == OP_LOAD) &&
                (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        case (funct3[1:0])
            2'b00:   be_c = 4'b0001 << bus.addr[1:0];
            2'b01:   be_c = bus.addr[1] ? 4'b1100 : 4'b0011;
            default: be_c = 4'b1111;
        endcase
        mis_c = (is_st || is_ld) &&
                (((funct3[1:0] == 2'b01) && bus.addr[0]) ||
                 ((funct3[1:0] == 2'b10) && (bus.addr[1:0] != 2'b00)));
    end

    // State and latency counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next-state logic; counter restarts at zero on every state entry.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        accept  = 1'b0;
        capture = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.req) begin
                    accept = 1'b1;
                    cnt_n  = '0;
                    if (is_st && !mis_c)      state_n = S_WRITE;
                    else if (is_ld && !mis_c) state_n = S_READ;
                    else                      state_n = S_DONE;
                end
            end
            S_WRITE: begin
                if (cnt == CNT_W'(WR_LAT - 1)) begin
                    state_n = S_DONE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_READ: begin
                if (cnt == CNT_W'(RD_LAT)) begin
                    state_n = S_DONE;
                    cnt_n   = '0;
                    capture = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_DONE: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Registered status and strobes, derived from the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.mem_we <= 1'b0;
            bus.mem_re <= 1'b0;
        end else begin
            bus.busy   <= (state_n != S_IDLE);
            bus.done   <= (state_n == S_DONE);
            bus.mem_we <= (state_n == S_WRITE);
            bus.mem_re <= (state_n == S_READ) && (cnt_n == '0);
        end
    end

    // Request payload held from accept to the next accept; load data captured at end of READ.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_be    <= '0;
            bus.misalign  <= 1'b0;
            bus.rdata     <= '0;
        end else begin
            if (accept) begin
                bus.mem_addr  <= bus.addr[ADDR_W+1:2];
                bus.mem_wdata <= bus.wdata;
                bus.mem_be    <= be_c;
                bus.misalign  <= mis_c;
            end
            if (capture) begin
                bus.rdata <= bus.mem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: transaction-level model plus RAM stub.
module tb_dmem_ctrl;
    localparam int unsigned ADDR_W = 14;
    localparam int unsigned RD_LAT = 2;
    localparam int unsigned WR_LAT = 1;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    logic cmp_en = 1'b0;

    dmem_ctrl_if #(.ADDR_W(ADDR_W)) bus();

    dmem_ctrl #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%08h exp=%08h t=%0t", name, act, exp, $time);
        end
    endtask

    // RAM stub: byte-enabled writes, RD_LAT-deep read pipe, garbage when not valid.
    logic [31:0] ram [0:DEPTH-1];
    logic [31:0] pipe [0:RD_LAT-1];
    assign bus.mem_rdata = pipe[RD_LAT-1];

    always @(posedge clk) begin
        if (bus.mem_we === 1'b1)
            for (int i = 0; i < 4; i++)
                if (bus.mem_be[i]) ram[bus.mem_addr][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
        pipe[0] <= (bus.mem_re === 1'b1) ? ram[bus.mem_addr] : $urandom;
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end

    // Behavioural model: each accepted access is a fixed-length timeline.
    typedef struct {int kind; int size; logic mis; logic [3:0] be;} dec_t;

    function automatic dec_t decode(input logic [31:0] ir, input logic [31:0] a);
        dec_t d;
        int   f3;
        int   off;
        d.kind = 0; d.size = 0; d.mis = 1'b0; d.be = 4'h0;
        f3 = int'(ir[14:12]);
        if (ir[6:0] == 7'h23 && f3 <= 2) begin
            d.kind = 1; d.size = 1 << f3;
        end else if (ir[6:0] == 7'h03 && (f3 <= 2 || f3 == 4 || f3 == 5)) begin
            d.kind = 2; d.size = 1 << (f3 % 4);
        end
        if (d.kind != 0) begin
            off   = int'(a % 4);
            d.mis = (off % d.size) != 0;
            d.be  = 4'(((1 << d.size) - 1) << (off & ~(d.size - 1)));
        end
        return d;
    endfunction

    logic [31:0]       shadow [0:DEPTH-1];
    dec_t              cur_dec;
    logic              m_act;
    int unsigned       m_t, m_done_t;
    int                m_kind;
    logic [31:0]       m_ld_val, m_st_data;
    logic [3:0]        m_st_be;
    logic [ADDR_W-1:0] m_st_idx;
    logic [31:0]       e_rdata, e_wdata;
    logic [ADDR_W-1:0] e_addr;
    logic [3:0]        e_be;
    logic              e_be_known, e_mis;
    int                acc_count = 0;

    always_comb cur_dec = decode(bus.ir, bus.addr);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_act <= 1'b0; m_t <= 0; m_done_t <= 0; m_kind <= 0;
            e_rdata <= '0; e_wdata <= '0; e_addr <= '0; e_be <= '0;
            e_be_known <= 1'b1; e_mis <= 1'b0;
        end else if (m_act) begin
            if (m_kind == 1 && m_t == 0)
                for (int i = 0; i < 4; i++)
                    if (m_st_be[i]) shadow[m_st_idx][8*i +: 8] <= m_st_data[8*i +: 8];
            if (m_t == m_done_t) begin
                m_act <= 1'b0;
            end else begin
                m_t <= m_t + 1;
                if (m_t + 1 == m_done_t && m_kind == 2) e_rdata <= m_ld_val;
            end
        end else if (bus.req === 1'b1) begin
            acc_count  <= acc_count + 1;
            m_act      <= 1'b1;
            m_t        <= 0;
            e_addr     <= ADDR_W'(bus.addr >> 2);
            e_wdata    <= bus.wdata;
            e_mis      <= cur_dec.mis;
            e_be       <= cur_dec.be;
            e_be_known <= (cur_dec.kind != 0);
            m_st_idx   <= ADDR_W'(bus.addr >> 2);
            m_st_be    <= cur_dec.be;
            m_st_data  <= bus.wdata;
            m_ld_val   <= shadow[ADDR_W'(bus.addr >> 2)];
            if (cur_dec.kind == 0 || cur_dec.mis) begin
                m_kind <= 0; m_done_t <= 0;
            end else if (cur_dec.kind == 1) begin
                m_kind <= 1; m_done_t <= WR_LAT;
            end else begin
                m_kind <= 2; m_done_t <= RD_LAT + 1;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("busy",     32'(bus.busy),      32'(m_act));
            check("done",     32'(bus.done),      32'(m_act && m_t == m_done_t));
            check("mem_we",   32'(bus.mem_we),    32'(m_act && m_kind == 1 && m_t < WR_LAT));
            check("mem_re",   32'(bus.mem_re),    32'(m_act && m_kind == 2 && m_t == 0));
            check("rdata",    bus.rdata,          e_rdata);
            check("misalign", 32'(bus.misalign),  32'(e_mis));
            check("mem_addr", 32'(bus.mem_addr),  32'(e_addr));
            check("mem_wdata", bus.mem_wdata,     e_wdata);
            if (e_be_known) check("mem_be", 32'(bus.mem_be), 32'(e_be));
        end
    end

    int we_cnt = 0, re_cnt = 0, dn_cnt = 0;
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) we_cnt <= we_cnt + 1;
        if (bus.mem_re === 1'b1) re_cnt <= re_cnt + 1;
        if (bus.done === 1'b1)   dn_cnt <= dn_cnt + 1;
    end

    localparam logic [31:0] IR_SW = 32'h0000_2023;
    localparam logic [31:0] IR_SH = 32'h0000_1023;
    localparam logic [31:0] IR_SB = 32'h0000_0023;
    localparam logic [31:0] IR_LW = 32'h0000_2003;

    // Wait for the model to accept the driven request; returns at the first negedge after E0.
    task automatic wait_accept(input int a0);
        int n = 0;
        while (acc_count == a0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (acc_count == a0) begin
            failures++;
            $display("FAIL accept_timeout act=none exp=accept");
        end
    endtask

    task automatic txn(input logic [31:0] t_ir, input logic [31:0] t_addr,
                       input logic [31:0] t_wdata, input logic poke,
                       output int lat, output int nwe, output int nre);
        int a0, w0, r0, i;
        @(negedge clk); #1;
        w0 = we_cnt; r0 = re_cnt; a0 = acc_count;
        bus.req = 1'b1; bus.ir = t_ir; bus.addr = t_addr; bus.wdata = t_wdata;
        wait_accept(a0);
        #1 bus.req = 1'b0;
        lat = 0; i = 0;
        while (lat == 0 && i < 16) begin
            if (bus.done === 1'b1) lat = i + 1;
            @(negedge clk); #1;
            if (poke && i == 0) begin
                bus.req = 1'b1; bus.ir = IR_SW; bus.addr = 32'h0000_0200; bus.wdata = 32'h1111_2222;
            end else begin
                bus.req = 1'b0;
            end
            i++;
        end
        bus.req = 1'b0;
        if (lat == 0) begin
            failures++;
            $display("FAIL done_timeout act=none exp=done");
        end
        @(negedge clk); @(negedge clk); #1;
        nwe = we_cnt - w0;
        nre = re_cnt - r0;
    endtask

    function automatic logic [31:0] rand_ir();
        logic [31:0] v;
        int r;
        v = $urandom;
        r = $urandom_range(0, 9);
        v[6:0] = (r < 4) ? 7'h23 : (r < 8) ? 7'h03 : 7'($urandom);
        return v;
    endfunction

    initial begin
        int lat, nwe, nre, d0, a0;
        for (int i = 0; i < DEPTH; i++) begin
            ram[i] = '0; shadow[i] = '0;
        end
        for (int i = 0; i < RD_LAT; i++) pipe[i] = '0;
        bus.req = 1'b1; bus.ir = IR_SW; bus.addr = 32'h0000_0100; bus.wdata = 32'hDEAD_BEEF;

        // Reset with a request held: nothing may be accepted.
        @(negedge clk);
        cmp_en = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_we", 32'(bus.mem_we), 32'h0);
        check("rst_be", 32'(bus.mem_be), 32'h0);
        check("rst_rdata", bus.rdata, 32'h0);
        #1 rst = 1'b0;

        // SW accepted on the first edge after release.
        @(negedge clk);
        check("sw_busy", 32'(bus.busy), 32'h1);
        check("sw_we", 32'(bus.mem_we), 32'h1);
        check("sw_addr", 32'(bus.mem_addr), 32'h040);
        check("sw_be", 32'(bus.mem_be), 32'hF);
        check("sw_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        #1 bus.req = 1'b0;
        @(negedge clk);
        check("sw_done", 32'(bus.done), 32'h1);
        check("sw_we_off", 32'(bus.mem_we), 32'h0);
        check("sw_mis", 32'(bus.misalign), 32'h0);

        // LW with an ignored request while busy.
        txn(IR_LW, 32'h0000_0100, 32'h0, 1'b1, lat, nwe, nre);
        check("lw_lat", 32'(lat), 32'd4);
        check("lw_rdata", bus.rdata, 32'hDEAD_BEEF);
        check("lw_re_pulses", 32'(nre), 32'd1);
        check("lw_we_pulses", 32'(nwe), 32'd0);

        // SB into the top byte; rdata must not move.
        txn(IR_SB, 32'h0000_0103, 32'h7878_7878, 1'b0, lat, nwe, nre);
        check("sb_lat", 32'(lat), 32'd2);
        check("sb_be", 32'(bus.mem_be), 32'h8);
        check("sb_addr", 32'(bus.mem_addr), 32'h040);
        check("sb_we_pulses", 32'(nwe), 32'd1);
        check("sb_rdata", bus.rdata, 32'hDEAD_BEEF);
        check("model_sb_be", 32'(e_be), 32'h8);

        txn(IR_LW, 32'h0000_0100, 32'h0, 1'b0, lat, nwe, nre);
        check("lw2_rdata", bus.rdata, 32'h78AD_BEEF);
        check("model_lw2", e_rdata, 32'h78AD_BEEF);

        // Misaligned half and word accesses.
        txn(IR_SH, 32'h0000_0101, 32'h5555_5555, 1'b0, lat, nwe, nre);
        check("sh_mis_lat", 32'(lat), 32'd1);
        check("sh_mis", 32'(bus.misalign), 32'h1);
        check("sh_mis_be", 32'(bus.mem_be), 32'h3);
        check("sh_mis_pulses", 32'(nwe + nre), 32'd0);
        txn(IR_LW, 32'h0000_0102, 32'h0, 1'b0, lat, nwe, nre);
        check("lw_mis_lat", 32'(lat), 32'd1);
        check("lw_mis", 32'(bus.misalign), 32'h1);
        check("lw_mis_pulses", 32'(nwe + nre), 32'd0);
        check("lw_mis_rdata", bus.rdata, 32'h78AD_BEEF);

        // Reset in the READ cycle with cnt=1.
        @(negedge clk); #1;
        a0 = acc_count;
        bus.req = 1'b1; bus.ir = IR_LW; bus.addr = 32'h0000_0100;
        wait_accept(a0);
        #1 bus.req = 1'b0;
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        check("rst_mid_busy", 32'(bus.busy), 32'h0);
        check("rst_mid_re", 32'(bus.mem_re), 32'h0);
        check("rst_mid_rdata", bus.rdata, 32'h0);
        check("rst_mid_done", 32'(bus.done), 32'h0);
        @(negedge clk); #1 rst = 1'b0;
        d0 = dn_cnt;
        repeat (6) @(negedge clk);
        check("rst_no_done", 32'(dn_cnt - d0), 32'd0);
        txn(IR_SW, 32'h0000_0104, 32'hCAFE_F00D, 1'b0, lat, nwe, nre);
        check("post_rst_sw_lat", 32'(lat), 32'd2);
        check("post_rst_sw_we", 32'(nwe), 32'd1);

        // Randomized traffic, including requests while busy, wrapping addresses and rare resets.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk); #1;
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 399) == 0) rst = 1'b1;
            bus.req   = ($urandom_range(0, 2) != 0);
            bus.ir    = rand_ir();
            bus.addr  = ($urandom & 32'hFFFF_0000) | (32'($urandom_range(0, 31)) << 2) |
                        32'($urandom_range(0, 3));
            bus.wdata = $urandom;
        end
        @(negedge clk); #1;
        rst = 1'b0;
        bus.req = 1'b0;
        repeat (20) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory access controller between the CPU datapath and a synchronous word-wide data RAM with byte-write enables. It accepts one load or store request at a time and decodes width and alignment from the instruction register. For stores it drives the already-replicated store data from the store converter onto the RAM with the matching byte enables. For loads it fetches the raw 32-bit word for the downstream load converter, handling the RAM's fixed read latency with a small state machine.

## Interface
- `ADDR_W`, 14, RAM word-address width; RAM holds 2^ADDR_W words.
- `RD_LAT`, 1, cycles from the edge that samples `mem_re` to `mem_rdata` being valid; legal range 1..4.
- `WR_LAT`, 1, cycles `mem_we` stays asserted per store; legal range 1..4.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `req` in 1: access request; sampled only in IDLE.
- `ir` in 32: instruction register; `ir[6:0]` is the opcode, `ir[14:12]` is funct3.
- `addr` in 32: byte address.
- `wdata` in 32: store data, already replicated per width.
- `busy` out 1: high whenever state is not IDLE.
- `done` out 1: one-cycle completion pulse.
- `rdata` out 32: last loaded word; held until the next load completes.
- `misalign` out 1: valid while `done` is high; 1 means the access was misaligned and not performed.
- `mem_addr` out ADDR_W: RAM word address.
- `mem_wdata` out 32: RAM write data.
- `mem_be` out 4: byte enables; bit i covers byte i (bits 8i+7:8i).
- `mem_we` out 1: RAM write strobe.
- `mem_re` out 1: RAM read strobe.
- `mem_rdata` in 32: RAM read data.

## Operation
- Decode happens on `ir` at the accept edge (IDLE with `req`=1).
  - Store: opcode 0100011. Funct3 000 = SB, 001 = SH, 010 = SW.
  - Load: opcode 0000011. Funct3 000/100 = byte, 001/101 = half, 010 = word.
  - Any other opcode, or an unlisted funct3, is a no-op.
- Byte enables:
  - Byte access: 0001 << `addr[1:0]`.
  - Half access: 0011 if `addr[1]`=0, else 1100.
  - Word access: 1111.
  - Loads compute `mem_be` the same way; the RAM ignores it on reads.
- Misalignment: a half access with `addr[0]`=1, or a word access with `addr[1:0]`≠00. A misaligned access makes no RAM access and sets `misalign`=1.
- At accept, register the following and hold them stable until the next accept:
  - `mem_addr` = `addr[ADDR_W+1:2]`; upper address bits are ignored, so addresses wrap.
  - `mem_wdata` = `wdata`.
  - `mem_be` as computed above.
- States:
  - IDLE. Aligned store → WRITE. Aligned load → READ. No-op or misaligned → DONE.
  - WRITE: `mem_we`=1 for exactly WR_LAT cycles (counter), then → DONE.
  - READ: counter `cnt` runs 0..RD_LAT. `mem_re`=1 only when `cnt`=0. At `cnt`=RD_LAT, `mem_rdata` is captured into `rdata` → DONE.
  - DONE: `done`=1 for one cycle, then → IDLE.
- `misalign` is registered at accept and cleared on the next accept.
- `rdata` changes only on a load capture. Stores, no-ops and misaligned accesses leave it unchanged.
- `req` while `busy`=1 is ignored; the requester must hold or re-present it in IDLE.

## Timing
- Reset values: state IDLE, counters 0, and every output 0 (`busy`, `done`, `rdata`, `misalign`, `mem_addr`, `mem_wdata`, `mem_be`, `mem_we`, `mem_re`).
- Let the accept edge be E0.
  - Store: `mem_we` high in cycles E0..E0+WR_LAT; `done` high in the cycle after E0+WR_LAT. Latency from E0 to `done` = WR_LAT+1 cycles.
  - Load: `mem_re` high in the cycle after E0; `rdata` updates at edge E0+RD_LAT+1; `done` is high with the new `rdata` visible. Latency = RD_LAT+2.
  - No-op or misaligned: `done` high in the cycle after E0. Latency = 1.
- `busy` rises after E0 and falls on the edge ending the DONE cycle. Earliest next accept is the first IDLE cycle; there is one bubble cycle after `done`.
- Reset mid-operation: asynchronous return to IDLE.
  - `mem_we` and `mem_re` drop immediately.
  - An in-flight load never updates `rdata`; `rdata` is 0 after reset.
  - No `done` is produced for the aborted access.

## Test plan
- Reset with `req`=1 held → all outputs 0; no accept while `rst`=1; first accept on the first edge after release.
- SW, `addr`=0x00000100, `wdata`=0xDEADBEEF, WR_LAT=1 → `mem_addr`=0x040, `mem_be`=1111, `mem_we` high for one cycle, `done` two cycles after E0, `misalign`=0.
- SB, `addr`=0x00000103, `wdata`=0x78787878 → `mem_be`=1000, `mem_addr`=0x040, a single `mem_we` cycle; `rdata` unchanged.
- LW, `addr`=0x00000100, RD_LAT=2, RAM model returning 0xDEADBEEF → `mem_re` high for exactly one cycle, `rdata`=0xDEADBEEF with `done` four cycles after E0; a `req` pulse while busy is ignored.
- SH at 0x00000101, then LW at 0x00000102 → each gives `done` one cycle after accept with `misalign`=1; no `mem_we` or `mem_re` pulses.
- `rst` asserted in the READ cycle where `cnt`=1 (RD_LAT=2) → `mem_re`=0 and `busy`=0 immediately, `rdata`=0, no `done`; the next SW completes normally.
